pcm_port_arbiter: RTL and testbench

PCM_PORT_ARBITER -- requirements
Module: pcm_port_arbiter

---
 rtl/pcm_port_arbiter_pkg.sv | 15 +
 rtl/pcm_port_arbiter_if.sv | 41 ++++
 rtl/pcm_port_arbiter_rr_pick.sv | 28 ++
 rtl/pcm_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_pcm_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcm_port_arbiter_pkg.sv
// Shared types and widths for the PCM port arbiter slice.
package pcm_arb_pkg;

    localparam int unsigned CPU_AW     = 20;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned DEF_MEM_AW = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } arb_state_t;

endpackage

// File: rtl/pcm_port_arbiter_if.sv
// CPU request bus plus PCM memory bus seen by the arbiter.
interface pcm_port_arbiter_if
    import pcm_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned MEM_AW  = DEF_MEM_AW
);

    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0]             req_we;
    logic [NUM_REQ-1:0][CPU_AW-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]             ready;
    logic [NUM_REQ-1:0]             err;
    logic [DATA_W-1:0]              rdata;

    logic                           mem_chipselect;
    logic                           mem_clken;
    logic                           mem_write;
    logic [MEM_AW-1:0]              mem_address;
    logic [DATA_W-1:0]              mem_writedata;
    logic [1:0]                     mem_byteenable;
    logic [DATA_W-1:0]              mem_readdata;

    // Requesters and memory side.
    modport master (
        output req, req_we, req_addr, req_wdata, mem_readdata,
        input  ready, err, rdata,
        input  mem_chipselect, mem_clken, mem_write, mem_address,
        input  mem_writedata, mem_byteenable
    );

    // Arbiter side.
    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_readdata,
        output ready, err, rdata,
        output mem_chipselect, mem_clken, mem_write, mem_address,
        output mem_writedata, mem_byteenable
    );

endinterface

// File: rtl/pcm_port_arbiter_rr_pick.sv
// Combinational round-robin selector: search starts one past last_grant.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    logic [IDW-1:0] idx;

    // Walk requesters from last_grant+1 around to last_grant, first hit wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = IDW'((32'(last_grant) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcm_port_arbiter.sv
// Round-robin arbiter sharing one PCM memory port among NUM_REQ CPUs.
module pcm_port_arbiter
    import pcm_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned MEM_AW      = DEF_MEM_AW
) (
    input  logic                clk,
    input  logic                reset,
    pcm_port_arbiter_if.slave   bus,
    output logic                busy,
    output logic [1:0]          grant_id
);

    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t          state, state_nx;
    logic [IDW-1:0]      last_grant;
    logic [IDW-1:0]      cur_id;
    logic                lat_we;
    logic                lat_err;
    logic [MEM_AW-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          wait_cnt;

    logic [NUM_REQ-1:0]  pick_oh;
    logic                pick_valid;
    logic [IDW-1:0]      pick_id;
    logic                sel_we;
    logic [CPU_AW-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_oor;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .req        (bus.req),
        .last_grant (last_grant),
        .grant      (pick_oh),
        .valid      (pick_valid)
    );

    // One-hot grant to index.
    always_comb begin
        pick_id = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) pick_id = IDW'(i);
        end
    end

    assign sel_we    = bus.req_we[pick_id];
    assign sel_addr  = bus.req_addr[pick_id];
    assign sel_wdata = bus.req_wdata[pick_id];
    assign sel_oor   = |sel_addr[CPU_AW-1:MEM_AW];

    assign bus.rdata          = rdata_q;
    assign bus.mem_writedata  = lat_wdata;
    assign bus.mem_byteenable = 2'b11;
    assign busy               = (state != ST_IDLE);
    assign grant_id           = 2'(cur_id);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Request latch, grant history, latency counter and read-data capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= IDW'(NUM_REQ - 1);
            cur_id     <= '0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_q    <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        last_grant <= pick_id;
                        cur_id     <= pick_id;
                        lat_we     <= sel_we;
                        lat_err    <= sel_oor;
                        lat_addr   <= sel_addr[MEM_AW-1:0];
                        lat_wdata  <= sel_wdata;
                        // Cleared per transaction so errored accesses return zero.
                        rdata_q    <= '0;
                    end
                end
                ST_ISSUE: wait_cnt <= 2'(MEM_LATENCY - 1);
                ST_WAIT: begin
                    if (wait_cnt == '0) rdata_q  <= bus.mem_readdata;
                    else                wait_cnt <= wait_cnt - 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Next-state and memory/handshake output decode.
    always_comb begin
        state_nx           = state;
        bus.mem_chipselect = 1'b0;
        bus.mem_clken      = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_address    = '0;
        bus.ready          = '0;
        bus.err            = '0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) state_nx = sel_oor ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                bus.mem_chipselect = 1'b1;
                bus.mem_clken      = 1'b1;
                bus.mem_write      = lat_we;
                bus.mem_address    = lat_addr;
                state_nx           = lat_we ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                bus.mem_clken   = 1'b1;
                bus.mem_address = lat_addr;
                if (wait_cnt == '0) state_nx = ST_DONE;
            end
            ST_DONE: begin
                bus.ready[cur_id] = 1'b1;
                bus.err[cur_id]   = lat_err;
                state_nx          = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pcm_port_arbiter.sv
// Table-driven and scoreboard bench for pcm_port_arbiter (MEM_LATENCY=1).
module tb_pcm_port_arbiter;

    typedef struct {
        logic [1:0]  cpu;
        logic        we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic        mutate;
        logic        exp_err;
        logic [15:0] exp_rdata;
        int unsigned exp_lat;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic        we;
        logic        err;
        logic [15:0] rdata;
        logic [15:0] wdata;
        logic [10:0] maddr;
        int unsigned lat;
        int          start;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic [1:0] grant_id;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int cs_cnt = 0;
    int wr_cnt = 0;
    logic [10:0] cs_addr;
    logic [15:0] cs_wdata;
    exp_t sb[$];
    vec_t vecs[13];

    logic [15:0] mem [0:2047];
    logic [15:0] mem_q;

    pcm_port_arbiter_if #(.NUM_REQ(4), .MEM_AW(11)) bus ();

    pcm_port_arbiter #(
        .NUM_REQ     (4),
        .MEM_LATENCY (1),
        .MEM_AW      (11)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency synchronous PCM model.
    always @(posedge clk) begin
        if (bus.mem_clken && bus.mem_chipselect) begin
            if (bus.mem_write) mem[bus.mem_address] <= bus.mem_writedata;
            else               mem_q <= mem[bus.mem_address];
        end
    end
    assign bus.mem_readdata = mem_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic we, input logic err,
                        input logic [15:0] rdata, input logic [15:0] wdata,
                        input logic [19:0] addr, input int unsigned lat);
        exp_t e;
        e.id = id; e.we = we; e.err = err; e.rdata = rdata; e.wdata = wdata;
        e.maddr = addr[10:0]; e.lat = lat; e.start = cyc;
        sb.push_back(e);
    endtask

    task automatic raise(input logic [1:0] cpu, input logic we,
                         input logic [19:0] addr, input logic [15:0] wdata);
        bus.req_we[cpu]    = we;
        bus.req_addr[cpu]  = addr;
        bus.req_wdata[cpu] = wdata;
        bus.req[cpu]       = 1'b1;
    endtask

    task automatic wait_ready_drop(input logic [1:0] cpu);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (bus.ready[cpu]) seen = 1'b1;
        end
        if (!seen) chk("ready_timeout", 32'(seen), 32'd1);
        @(posedge clk);
        #1 bus.req[cpu] = 1'b0;
    endtask

    task automatic cpu_two(input logic [1:0] cpu);
        wait_ready_drop(cpu);
        raise(cpu, 1'b0, 20'h00100 + 20'(cpu), 16'h0);
        wait_ready_drop(cpu);
    endtask

    // Pops the scoreboard on every ready pulse and checks the whole transaction.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cs_cnt = 0;
                wr_cnt = 0;
            end else begin
                if (bus.mem_chipselect) begin
                    cs_cnt++;
                    if (bus.mem_write) wr_cnt++;
                    cs_addr  = bus.mem_address;
                    cs_wdata = bus.mem_writedata;
                end
                if (bus.ready != '0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_ready", 32'(bus.ready), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("ready_vec", 32'(bus.ready), 32'(4'b0001 << e.id));
                        chk("err_vec", 32'(bus.err), e.err ? 32'(4'b0001 << e.id) : 32'd0);
                        chk("grant_id", 32'(grant_id), 32'(e.id));
                        if (e.err || !e.we) chk("rdata", 32'(bus.rdata), 32'(e.rdata));
                        if (e.lat != 0) chk("latency", 32'(cyc - e.start), e.lat);
                        chk("cs_cycles", 32'(cs_cnt), e.err ? 32'd0 : 32'd1);
                        chk("wr_cycles", 32'(wr_cnt), (e.we && !e.err) ? 32'd1 : 32'd0);
                        if (!e.err) chk("mem_addr", 32'(cs_addr), 32'(e.maddr));
                        if (e.we && !e.err) chk("mem_wdata", 32'(cs_wdata), 32'(e.wdata));
                    end
                    cs_cnt = 0;
                    wr_cnt = 0;
                end
            end
        end
    endtask

    initial begin
        vecs[0]  = '{2'd1, 1'b1, 20'h00010, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 2};
        vecs[1]  = '{2'd1, 1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 3};
        vecs[2]  = '{2'd2, 1'b1, 20'h007FF, 16'h1234, 1'b0, 1'b0, 16'h0000, 2};
        vecs[3]  = '{2'd2, 1'b0, 20'h007FF, 16'h0000, 1'b0, 1'b0, 16'h1234, 3};
        vecs[4]  = '{2'd3, 1'b0, 20'h00800, 16'h0000, 1'b0, 1'b1, 16'h0000, 1};
        vecs[5]  = '{2'd0, 1'b1, 20'h00021, 16'h2222, 1'b0, 1'b0, 16'h0000, 2};
        vecs[6]  = '{2'd0, 1'b1, 20'h00020, 16'h7777, 1'b1, 1'b0, 16'h0000, 2};
        vecs[7]  = '{2'd1, 1'b0, 20'h00020, 16'h0000, 1'b0, 1'b0, 16'h7777, 3};
        vecs[8]  = '{2'd3, 1'b0, 20'h00021, 16'h0000, 1'b0, 1'b0, 16'h2222, 3};
        vecs[9]  = '{2'd3, 1'b1, 20'hFFFFF, 16'hAAAA, 1'b0, 1'b1, 16'h0000, 1};
        vecs[10] = '{2'd0, 1'b0, 20'h007FF, 16'h0000, 1'b0, 1'b0, 16'h1234, 3};
        vecs[11] = '{2'd1, 1'b1, 20'h00400, 16'h0F0F, 1'b0, 1'b0, 16'h0000, 2};
        vecs[12] = '{2'd0, 1'b0, 20'h00400, 16'h0000, 1'b0, 1'b0, 16'h0F0F, 3};

        reset         = 1'b0;
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        fork monitor(); join_none

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_ready_err", {24'd0, bus.ready, bus.err}, 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_mem_ctl", {29'd0, bus.mem_chipselect, bus.mem_clken, bus.mem_write}, 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_address), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_writedata), 32'd0);
        chk("rst_byteen", 32'(bus.mem_byteenable), 32'd3);
        @(posedge clk);
        #1 reset = 1'b1;

        // Single-requester table.
        for (int unsigned k = 0; k < 13; k++) begin
            @(posedge clk);
            #1;
            push(vecs[k].cpu, vecs[k].we, vecs[k].exp_err, vecs[k].exp_rdata,
                 vecs[k].wdata, vecs[k].addr, vecs[k].exp_lat);
            raise(vecs[k].cpu, vecs[k].we, vecs[k].addr, vecs[k].wdata);
            if (vecs[k].mutate) begin
                @(posedge clk);
                #1;
                bus.req_addr[vecs[k].cpu]  = 20'h00021;
                bus.req_wdata[vecs[k].cpu] = 16'h1111;
            end
            wait_ready_drop(vecs[k].cpu);
        end

        // All four read together right after reset: order 0,1,2,3.
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        push(2'd0, 1'b0, 1'b0, 16'hBEEF, 16'h0, 20'h00010, 3);
        push(2'd1, 1'b0, 1'b0, 16'h1234, 16'h0, 20'h007FF, 0);
        push(2'd2, 1'b0, 1'b0, 16'h7777, 16'h0, 20'h00020, 0);
        push(2'd3, 1'b0, 1'b0, 16'h2222, 16'h0, 20'h00021, 0);
        raise(2'd0, 1'b0, 20'h00010, 16'h0);
        raise(2'd1, 1'b0, 20'h007FF, 16'h0);
        raise(2'd2, 1'b0, 20'h00020, 16'h0);
        raise(2'd3, 1'b0, 20'h00021, 16'h0);
        fork
            wait_ready_drop(2'd0);
            wait_ready_drop(2'd1);
            wait_ready_drop(2'd2);
            wait_ready_drop(2'd3);
        join

        // Continuous requests: writes 0..3 then reads 0..3.
        @(posedge clk);
        #1;
        for (int unsigned k = 0; k < 4; k++)
            push(2'(k), 1'b1, 1'b0, 16'h0, 16'hA000 + 16'(k), 20'h00100 + 20'(k), 0);
        for (int unsigned k = 0; k < 4; k++)
            push(2'(k), 1'b0, 1'b0, 16'hA000 + 16'(k), 16'h0, 20'h00100 + 20'(k), 0);
        for (int unsigned k = 0; k < 4; k++)
            raise(2'(k), 1'b1, 20'h00100 + 20'(k), 16'hA000 + 16'(k));
        fork
            cpu_two(2'd0);
            cpu_two(2'd1);
            cpu_two(2'd2);
            cpu_two(2'd3);
        join

        // Reset while a read sits in WAIT: abandoned without a ready pulse.
        @(posedge clk);
        #1 raise(2'd1, 1'b0, 20'h00010, 16'h0);
        begin
            logic in_wait;
            in_wait = 1'b0;
            for (int i = 0; i < 10 && !in_wait; i++) begin
                @(negedge clk);
                if (bus.mem_clken && !bus.mem_chipselect) in_wait = 1'b1;
            end
            chk("reach_wait", 32'(in_wait), 32'd1);
        end
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy_gid", {30'd0, busy, |grant_id}, 32'd0);
        chk("midrst_ready_err", {24'd0, bus.ready, bus.err}, 32'd0);
        chk("midrst_rdata", 32'(bus.rdata), 32'd0);
        chk("midrst_mem_ctl", {29'd0, bus.mem_chipselect, bus.mem_clken, bus.mem_write}, 32'd0);
        chk("midrst_mem_addr", 32'(bus.mem_address), 32'd0);
        bus.req = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        push(2'd0, 1'b0, 1'b0, 16'h7777, 16'h0, 20'h00020, 3);
        push(2'd2, 1'b0, 1'b0, 16'h1234, 16'h0, 20'h007FF, 0);
        raise(2'd0, 1'b0, 20'h00020, 16'h0);
        raise(2'd2, 1'b0, 20'h007FF, 16'h0);
        fork
            wait_ready_drop(2'd0);
            wait_ready_drop(2'd2);
        join

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
